// File: rtl/comparator_pkg.sv
// Shared types for the serial comparator: FSM states and branch funct3 codes.
// Also provides the funct3 -> taken decode used by the top.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  function automatic logic taken_f(
    input logic [2:0] m,
    input logic       e,
    input logic       l,
    input logic       lu
  );
    logic t;
    t = 1'b0;
    case (m)
      BEQ:     t = e;
      BNE:     t = !e;
      BLT:     t = l;
      BGE:     t = !l;
      BLTU:    t = lu;
      BGEU:    t = !lu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/serial_comparator_if.sv
// Request/result bundle of the serial comparator.
// master: requester side; slave: the comparator.
interface serial_comparator_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   mode;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic         eq;
  logic         lt;
  logic         ltu;
  logic         taken;

  modport master (
    output in_valid, a, b, mode, flush, out_ready,
    input  in_ready, out_valid, eq, lt, ltu, taken
  );

  modport slave (
    input  in_valid, a, b, mode, flush, out_ready,
    output in_ready, out_valid, eq, lt, ltu, taken
  );
endinterface

// File: rtl/serial_comparator_slice_compare.sv
// Combinational CHUNK-bit slice compare.
// Ports: a_slice, b_slice in; slice_eq, slice_ltu (unsigned a<b) out.
module slice_compare #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_slice,
  input  logic [CHUNK-1:0] b_slice,
  output logic             slice_eq,
  output logic             slice_ltu
);
  assign slice_eq  = (a_slice == b_slice);
  assign slice_ltu = (a_slice < b_slice);
endmodule

// File: rtl/serial_comparator.sv
// Multi-cycle comparator: scans CHUNK bits per cycle from the MSB, exits early.
// Ports: clock, nReset (sync, active-low), bus (slave side of the bundle).
module serial_comparator
  import comparator_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input logic                 clock,
  input logic                 nReset,
  serial_comparator_if.slave  bus
);

  if ((CHUNK < 1) || (CHUNK > N) || ((N % CHUNK) != 0)) begin : g_bad_cfg
    $error("serial_comparator: need N %% CHUNK == 0 and CHUNK <= N");
  end

  localparam int NC = N / CHUNK;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [2:0]     mode_q, mode_d;
  logic           eq_q, eq_d;
  logic           lt_q, lt_d;
  logic           ltu_q, ltu_d;
  logic           taken_q, taken_d;
  logic           in_ready;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic             sl_eq;
  logic             sl_ltu;

  assign a_sl = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign b_sl = b_q[int'(idx_q) * CHUNK +: CHUNK];

  slice_compare #(.CHUNK(CHUNK)) u_slice (
    .a_slice   (a_sl),
    .b_slice   (b_sl),
    .slice_eq  (sl_eq),
    .slice_ltu (sl_ltu)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    ltu_d    = ltu_q;
    taken_d  = taken_q;
    in_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SCAN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (!sl_eq) begin
          eq_d    = 1'b0;
          ltu_d   = sl_ltu;
          // Sign bits differ: the negative operand is the smaller one.
          lt_d    = (a_q[N-1] != b_q[N-1]) ? a_q[N-1] : sl_ltu;
          taken_d = taken_f(mode_q, 1'b0, lt_d, ltu_d);
          state_d = DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          ltu_d   = 1'b0;
          taken_d = taken_f(mode_q, 1'b1, 1'b0, 1'b0);
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        in_ready = bus.out_ready;
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over both acceptance and completion.
    if ((state_q != IDLE) && bus.flush) begin
      eq_d    = 1'b0;
      lt_d    = 1'b0;
      ltu_d   = 1'b0;
      taken_d = 1'b0;
    end else if (in_ready && bus.in_valid) begin
      a_d     = bus.a;
      b_d     = bus.b;
      mode_d  = bus.mode;
      idx_d   = IW'(NC - 1);
      state_d = SCAN;
    end
  end

  always_ff @(posedge clock) begin
    if (!nReset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      ltu_q   <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      ltu_q   <= ltu_d;
      taken_q <= taken_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.eq        = eq_q;
  assign bus.lt        = lt_q;
  assign bus.ltu       = ltu_q;
  assign bus.taken     = taken_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator (N=32, CHUNK=8).
// Hand-computed vectors, latency, hold, back-to-back, flush and reset abort.
module tb_serial_comparator;

  logic clock;
  logic nReset;
  int   n_chk;
  int   n_fail;

  serial_comparator_if #(.N(32)) bus ();

  serial_comparator #(.N(32), .CHUNK(8)) dut (
    .clock  (clock),
    .nReset (nReset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic e, input logic l,
                           input logic lu, input logic t);
    chk({tag, ".eq"}, 32'(bus.eq), 32'(e));
    chk({tag, ".lt"}, 32'(bus.lt), 32'(l));
    chk({tag, ".ltu"}, 32'(bus.ltu), 32'(lu));
    chk({tag, ".taken"}, 32'(bus.taken), 32'(t));
  endtask

  // Present a request, pass the accept edge, then scramble operands.
  task automatic issue(input string tag, input logic [31:0] av,
                       input logic [31:0] bv, input logic [2:0] m);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    bus.mode     = m;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.a        = ~av;
    bus.b        = bv ^ 32'h5a5a5a5a;
    bus.mode     = ~m;
    chk({tag, ".scan_ov"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 12) begin
      tick();
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic retire(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, ".ret_ov"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".ret_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] av,
                     input logic [31:0] bv, input logic [2:0] m,
                     input int lat, input logic e, input logic l,
                     input logic lu, input logic t);
    issue(tag, av, bv, m);
    wait_done(tag, lat);
    chk_flags(tag, e, l, lu, t);
    retire(tag);
  endtask

  // Watch a few cycles to confirm no result ever appears.
  task automatic no_result(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk({tag, ".no_ov"}, 32'(seen), 32'd0);
    chk({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    nReset        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.mode      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    nReset = 1'b1;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);

    run("blt_5_10", 32'd5, 32'd10, 3'b100, 4, 1'b0, 1'b1, 1'b1, 1'b1);
    run("beq_5_5", 32'd5, 32'd5, 3'b000, 4, 1'b1, 1'b0, 1'b0, 1'b1);
    run("bltu_5_m1", 32'd5, 32'hffffffff, 3'b110, 1,
        1'b0, 1'b0, 1'b1, 1'b1);
    run("bge_min_1", 32'h80000000, 32'd1, 3'b101, 1,
        1'b0, 1'b1, 1'b0, 1'b0);
    run("bne_mid", 32'h12340000, 32'h12350000, 3'b001, 2,
        1'b0, 1'b1, 1'b1, 1'b1);
    run("m010_eq", 32'hdeadbeef, 32'hdeadbeef, 3'b010, 4,
        1'b1, 1'b0, 1'b0, 1'b0);
    run("bgeu_lsb", 32'hffffffff, 32'hfffffffe, 3'b111, 4,
        1'b0, 1'b0, 1'b0, 1'b1);
    run("blt_neg", 32'hfffffff0, 32'hffff0000, 3'b100, 3,
        1'b0, 1'b0, 1'b0, 1'b0);

    // Hold in DONE for 5 cycles, then back-to-back accept.
    issue("hold", 32'd5, 32'd10, 3'b100);
    wait_done("hold", 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold.ov", 32'(bus.out_valid), 32'd1);
      chk("hold.rdy", 32'(bus.in_ready), 32'd0);
      chk_flags("hold", 1'b0, 1'b1, 1'b1, 1'b1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("b2b.rdy", 32'(bus.in_ready), 32'd1);
    issue("b2b", 32'd5, 32'd5, 3'b000);
    bus.out_ready = 1'b0;
    wait_done("b2b", 4);
    chk_flags("b2b", 1'b1, 1'b0, 1'b0, 1'b1);
    retire("b2b");

    // Flush in the second SCAN cycle.
    issue("flush", 32'd5, 32'd5, 3'b000);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush.ov", 32'(bus.out_valid), 32'd0);
    chk("flush.rdy", 32'(bus.in_ready), 32'd1);
    no_result("flush");

    // Reset in the second SCAN cycle.
    issue("rst_scan", 32'd5, 32'd5, 3'b000);
    tick();
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
    chk("rst_scan.ov", 32'(bus.out_valid), 32'd0);
    chk("rst_scan.rdy", 32'(bus.in_ready), 32'd1);
    no_result("rst_scan");

    // Flush in DONE beats a simultaneous accept.
    issue("flush_done", 32'd1, 32'd2, 3'b110);
    wait_done("flush_done", 4);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("flush_done.ov", 32'(bus.out_valid), 32'd0);
    no_result("flush_done");

    // Post-abort request still works.
    run("after", 32'd7, 32'd3, 3'b101, 4, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
